bin_a_bcd_seq: RTL and testbench
================================

Name: bin_a_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly downstream of the parameterised D register and consumes its Q output. The converted digits drive the display/decoder stage. The conversion runs one bit per clock, with a START/DONE handshake, and the result is held stable between conversions.

Parameters:
REGISTRO_WIDTH, 8, width of the binary input. Matches the upstream register width.
NUM_DIGITS, 3, number of BCD digits. Must satisfy 10^NUM_DIGITS > 2^REGISTRO_WIDTH-1; an elaboration check fails otherwise.

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  synchronous, active-low reset (RST=0 resets on the next rising CLK edge)
START  input  1  request a conversion; sampled only in IDLE
BIN  input  REGISTRO_WIDTH  binary value, unsigned; sampled on the accepting edge only
BUSY  output  1  conversion in progress
DONE  output  1  one-cycle pulse: BCD was updated on the previous edge
BCD  output  4*NUM_DIGITS  result; digit 0 is in [3:0], least significant
BLANK  output  NUM_DIGITS  (only with the optional feature) leading-zero mask

Behaviour:
- Single clock domain.
- Reset (RST=0 at an edge): state=IDLE, BUSY=0, DONE=0, BCD=0, shift counter=0, scratch=0, BLANK=0. Reset has priority over everything, including an in-progress conversion; the conversion is aborted and no DONE is issued.
- States: IDLE, CONV. Encoding is 1 bit.
- IDLE:
  - If START=1 at edge k, load scratch = {NUM_DIGITS*4 zeros, BIN}, set counter=0, go to CONV.
  - BUSY=1 in the cycles following edges k .. k+REGISTRO_WIDTH-1.
- CONV, each edge:
  - For every digit >=5, add 3 (4-bit, no carry out).
  - Shift the whole scratch left 1.
  - Increment the counter.
- On the edge where the counter reaches REGISTRO_WIDTH (edge k+REGISTRO_WIDTH):
  - BCD <= adjusted-and-shifted digit field.
  - DONE <= 1, BUSY <= 0, state <= IDLE.
- DONE deasserts on the following edge.
- Latency: DONE is high in the cycle after edge k+REGISTRO_WIDTH. A START in that same cycle is accepted, so back-to-back throughput is one result per REGISTRO_WIDTH+1 cycles.
- START while in CONV is ignored; no queueing. Changes to BIN during CONV have no effect.
- BCD changes only on the completion edge or on reset. Otherwise it holds the last result.
- Boundary values:
  - BIN=0 gives BCD=0.
  - BIN=2^REGISTRO_WIDTH-1 gives the exact decimal result; no overflow is possible under the parameter constraint.
- Counter width: clog2(REGISTRO_WIDTH+1).

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: the BLANK port exists. Bit i=1 when digit i and all more-significant digits are zero. Bit 0 is always 0, so a lone zero still displays. BLANK is registered and updated on the same edge as BCD; it resets to 0.
- Undefined: the BLANK port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package bcd_pkg:
  - state constants ST_IDLE/ST_CONV
  - BCD_ADJ_THRESH=5
  - BCD_ADJ_ADD=3
  - DIGIT_W=4
- One sub-module, ajuste_digito: a combinational 4-bit "if >=5 add 3". It is instantiated NUM_DIGITS times in a generate loop.
- The FSM, counter and scratch register stay in the top module.

Test Plan (REGISTRO_WIDTH=8, NUM_DIGITS=3, CLK period 10 ns):
1. Hold RST=0 for 3 edges, then release -> BCD=12'h000, BUSY=0, DONE=0. BLANK=3'b000 before any conversion.
2. BIN=255, START pulse at edge k -> BUSY high 8 cycles, DONE high only after edge k+8, BCD=12'h255.
3. BIN=0, then BIN=100, then BIN=7, each as a separate conversion -> BCD=12'h000, 12'h100, 12'h007. With BCD_BLANK_EN: BLANK=3'b110, 3'b000, 3'b110.
4. BIN=9 with START. Hold START high and change BIN to 10 during CONV -> the first result is 12'h009. START held during the DONE cycle is accepted and gives 12'h010. DONE pulses are exactly 9 cycles apart.
5. BIN=200, START, then RST=0 at edge k+4 -> no DONE, BCD=12'h000, state IDLE. A new START with BIN=42 yields 12'h042.
6. Randomised sweep of all 256 BIN values, compared against a reference model -> exact match. BCD stays constant between DONE pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam int DIGIT_W        = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/ajuste_digito.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module ajuste_digito
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= DIGIT_W'(BCD_ADJ_THRESH)) begin
            d_o = d_i + DIGIT_W'(BCD_ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional leading-zero mask output BLANK is built when BCD_BLANK_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for START; BCD holds the last result
// ST_CONV | shifting scratch one bit per edge, REGISTRO_WIDTH edges
module bin_a_bcd_seq
    import bcd_pkg::*;
#(
    parameter int REGISTRO_WIDTH = 8,
    parameter int NUM_DIGITS     = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [REGISTRO_WIDTH-1:0]     BIN,
    output logic                          BUSY,
    output logic                          DONE,
`ifdef BCD_BLANK_EN
    output logic [DIGIT_W*NUM_DIGITS-1:0] BCD,
    output logic [NUM_DIGITS-1:0]         BLANK
`else
    output logic [DIGIT_W*NUM_DIGITS-1:0] BCD
`endif
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int SCR_W = BCD_W + REGISTRO_WIDTH;
    localparam int CNT_W = $clog2(REGISTRO_WIDTH + 1);

    if ((10 ** NUM_DIGITS) <= ((2 ** REGISTRO_WIDTH) - 1)) begin : g_bad_params
        $error("NUM_DIGITS too small to represent 2**REGISTRO_WIDTH-1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [SCR_W-1:0]   scr_adj, scr_shift;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;

    // Digit field sits above the binary field; only the digits get corrected.
    assign scr_adj[REGISTRO_WIDTH-1:0] = scr_q[REGISTRO_WIDTH-1:0];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        ajuste_digito u_adj (
            .d_i (scr_q  [REGISTRO_WIDTH + g*DIGIT_W +: DIGIT_W]),
            .d_o (scr_adj[REGISTRO_WIDTH + g*DIGIT_W +: DIGIT_W])
        );
    end

    assign scr_shift = scr_adj << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    scr_d   = {{BCD_W{1'b0}}, BIN};
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                scr_d = scr_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(REGISTRO_WIDTH - 1)) begin
                    bcd_d   = scr_shift[SCR_W-1:REGISTRO_WIDTH];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = (state_q == ST_CONV);
    assign DONE = done_q;
    assign BCD  = bcd_q;

`ifdef BCD_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  zero_run;

    // Bit 0 never blanks so a lone zero stays visible.
    always_comb begin
        blank_d  = blank_q;
        zero_run = 1'b1;
        if (done_d) begin
            blank_d = '0;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                zero_run   = zero_run && (bcd_d[i*DIGIT_W +: DIGIT_W] == '0);
                blank_d[i] = zero_run;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign BLANK = blank_q;
`endif

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Scoreboard bench for bin_a_bcd_seq (8-bit input, 3 digits); BLANK is
// checked when BCD_BLANK_EN is defined.
module tb_bin_a_bcd_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  BIN = '0;
    logic        BUSY, DONE;
    logic [11:0] BCD;
    logic [2:0]  BLANK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [11:0] exp_bcd_q[$];
    logic [2:0]  exp_blank_q[$];
    logic        chk_stable = 1'b0;
    logic [11:0] prev_bcd;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bin_a_bcd_seq #(.REGISTRO_WIDTH(8), .NUM_DIGITS(3)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
`ifdef BCD_BLANK_EN
        .BCD   (BCD),
        .BLANK (BLANK)
`else
        .BCD   (BCD)
`endif
    );

`ifndef BCD_BLANK_EN
    assign BLANK = 3'b000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        ref_blank = {v < 100, v < 10, 1'b0};
    endfunction

    task automatic push_exp(input int v);
        exp_bcd_q.push_back(ref_bcd(v));
        exp_blank_q.push_back(ref_blank(v));
    endtask

    // Output side of the scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_bcd_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [11:0] eb;
                logic [2:0]  el;
                eb = exp_bcd_q.pop_front();
                el = exp_blank_q.pop_front();
                chk("bcd_result", 32'(BCD), 32'(eb));
`ifdef BCD_BLANK_EN
                chk("blank_result", 32'(BLANK), 32'(el));
`endif
            end
        end else if (chk_stable) begin
            chk("bcd_hold", 32'(BCD), 32'(prev_bcd));
        end
        prev_bcd = BCD;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (DONE === 1'b1) break;
            step();
        end
        if (i == bound) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input int v, input bit full);
        BIN   = 8'(v);
        START = 1'b1;
        push_exp(v);
        step();
        START = 1'b0;
        BIN   = 8'($urandom);
        if (full) begin
            for (int i = 0; i < 8; i++) begin
                chk("busy_during_conv", 32'(BUSY), 32'd1);
                chk("no_early_done", 32'(DONE), 32'd0);
                step();
            end
            chk("done_pulse", 32'(DONE), 32'd1);
            chk("busy_after_conv", 32'(BUSY), 32'd0);
        end else begin
            wait_done(12);
        end
        step();
        chk("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    initial begin
        int vals[256];
        int t1, t2, ndone;

        // Reset state
        repeat (3) step();
        RST = 1'b1;
        step();
        chk("rst_bcd", 32'(BCD), 32'h000);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
`ifdef BCD_BLANK_EN
        chk("rst_blank", 32'(BLANK), 32'd0);
`endif

        // Full-range value and timing
        convert(255, 1'b1);
        chk("hold_255", 32'(BCD), 32'h255);

        // Boundary and assorted values
        convert(0, 1'b1);
        convert(100, 1'b1);
        convert(7, 1'b1);

        // START held through conversion and DONE cycle; BIN changes ignored
        BIN   = 8'd9;
        START = 1'b1;
        push_exp(9);
        step();
        BIN = 8'd10;
        push_exp(10);
        wait_done(20);
        t1 = cyc;
        step();
        START = 1'b0;
        BIN   = 8'd99;
        wait_done(20);
        t2 = cyc;
        chk("done_spacing", 32'(t2 - t1), 32'd9);
        step();

        // Reset mid-conversion aborts without DONE
        BIN   = 8'd200;
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        step();
        RST = 1'b1;
        chk("abort_bcd", 32'(BCD), 32'h000);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (DONE === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        convert(42, 1'b1);

        // Shuffled sweep of every input value
        for (int i = 0; i < 256; i++) vals[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(i, 0);
            tmp = vals[i];
            vals[i] = vals[j];
            vals[j] = tmp;
        end
        @(negedge CLK);
        #1;
        chk_stable = 1'b1;
        step();
        for (int i = 0; i < 256; i++) begin
            convert(vals[i], 1'b0);
            if (($urandom & 3) == 0) step();
        end
        chk_stable = 1'b0;

        chk("queue_empty", 32'(exp_bcd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
